// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: geometry, address slicing
// helpers, miss-unit state encoding and the memory request payload.
package cache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned INDEX_W  = 14;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_FILL
  } miss_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Line index: the bits just above the word offset.
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return INDEX_W'(addr >> OFFSET_W);
  endfunction

  // Tag: everything above the index.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (OFFSET_W + INDEX_W));
  endfunction

  // Word-aligned byte address (offset bits cleared).
  function automatic logic [ADDR_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << OFFSET_W) - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dm_cache_miss_unit.sv
// Miss handler behind the direct-mapped lookup: one miss at a time, load
// misses fetched and filled, store misses written through without allocate.
module dm_cache_miss_unit
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic               miss_is_store,
  input  logic [ADDR_W-1:0]  miss_addr,
  input  logic [DATA_W-1:0]  miss_wdata,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_we,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [DATA_W-1:0]  mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_data,
  output logic               fill_valid,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [DATA_W-1:0]  fill_data,
  output logic               busy,
  output logic [CNT_W-1:0]   load_miss_cnt,
  output logic [CNT_W-1:0]   store_miss_cnt
);

  miss_state_e        state, state_nxt;
  mem_req_t           req_q, req_nxt;
  logic [INDEX_W-1:0] index_nxt;
  logic [TAG_W-1:0]   tag_nxt;
  logic [DATA_W-1:0]  fill_data_nxt;
  logic               accept;
  logic               load_en;
  logic               store_en;

  assign accept = miss_valid && miss_ready;

  // Next state plus the payload captured on accept / response.
  always_comb begin
    state_nxt     = state;
    req_nxt       = req_q;
    index_nxt     = fill_index;
    tag_nxt       = fill_tag;
    fill_data_nxt = fill_data;
    load_en       = 1'b0;
    store_en      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt     = S_REQ;
          req_nxt.we    = miss_is_store;
          req_nxt.addr  = addr_word(miss_addr);
          req_nxt.wdata = miss_wdata;
          index_nxt     = addr_index(miss_addr);
          tag_nxt       = addr_tag(miss_addr);
          load_en       = !miss_is_store;
          store_en      = miss_is_store;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_nxt = req_q.we ? S_IDLE : S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          fill_data_nxt = mem_rsp_data;
          state_nxt     = S_FILL;
        end
      end
      S_FILL: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_q         <= '0;
      fill_index    <= '0;
      fill_tag      <= '0;
      fill_data     <= '0;
      miss_ready    <= 1'b1;
      mem_req_valid <= 1'b0;
      fill_valid    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      req_q         <= req_nxt;
      fill_index    <= index_nxt;
      fill_tag      <= tag_nxt;
      fill_data     <= fill_data_nxt;
      miss_ready    <= (state_nxt == S_IDLE);
      mem_req_valid <= (state_nxt == S_REQ);
      fill_valid    <= (state_nxt == S_FILL);
      busy          <= (state_nxt != S_IDLE);
    end
  end

  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .count (load_miss_cnt)
  );

  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (store_en),
    .count (store_miss_cnt)
  );

endmodule

// File: tb/tb_dm_cache_miss_unit.sv
// Directed plus randomized bench for dm_cache_miss_unit with a transaction-level
// reference model (expected request, fill fields, latency and counters).
module tb_dm_cache_miss_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_valid;
  logic        miss_ready;
  logic        miss_is_store;
  logic [31:0] miss_addr;
  logic [31:0] miss_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        fill_valid;
  logic [13:0] fill_index;
  logic [15:0] fill_tag;
  logic [31:0] fill_data;
  logic        busy;
  logic [31:0] load_miss_cnt;
  logic [31:0] store_miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] ld_exp = 0;
  logic [31:0] st_exp = 0;

  dm_cache_miss_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss_valid     (miss_valid),
    .miss_ready     (miss_ready),
    .miss_is_store  (miss_is_store),
    .miss_addr      (miss_addr),
    .miss_wdata     (miss_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .fill_valid     (fill_valid),
    .fill_index     (fill_index),
    .fill_tag       (fill_tag),
    .fill_data      (fill_data),
    .busy           (busy),
    .load_miss_cnt  (load_miss_cnt),
    .store_miss_cnt (store_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_ld_cnt"}, load_miss_cnt, ld_exp);
    chk({tag, "_st_cnt"}, store_miss_cnt, st_exp);
  endtask

  // One complete miss. Entered and left at a negedge. Optionally raises a
  // second miss while this load waits for memory and leaves it held.
  task automatic run_miss(input bit is_store, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int stall, input int rsp_delay, input bit spurious,
                          input bit hold, input bit h_store,
                          input logic [31:0] h_addr, input logic [31:0] h_wdata);
    int n;
    logic [31:0] waddr;
    waddr = addr - (addr % 4);
    miss_valid    = 1'b1;
    miss_is_store = is_store;
    miss_addr     = addr;
    miss_wdata    = wdata;
    chk("idle_ready", miss_ready, 1);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    miss_valid = 1'b0;
    miss_addr  = $urandom;
    miss_wdata = $urandom;
    if (is_store) st_exp = sat_inc(st_exp);
    else          ld_exp = sat_inc(ld_exp);
    chk("req_valid", mem_req_valid, 1);
    chk("req_we", mem_req_we, is_store);
    chk("req_addr", mem_req_addr, waddr);
    if (is_store) chk("req_wdata", mem_req_wdata, wdata);
    chk("busy_req", busy, 1);
    chk("ready_req", miss_ready, 0);
    chk_counters("accept");
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = spurious && (i == 0);
      mem_rsp_data  = $urandom;
      @(posedge clk);
      n++;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, waddr);
      chk("stall_we", mem_req_we, is_store);
      if (is_store) chk("stall_wdata", mem_req_wdata, wdata);
      chk("stall_fill", fill_valid, 0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    n++;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("req_dropped", mem_req_valid, 0);
    if (is_store) begin
      chk("st_busy_fall", busy, 0);
      chk("st_ready", miss_ready, 1);
      chk("st_no_fill", fill_valid, 0);
      return;
    end
    if (hold) begin
      miss_valid    = 1'b1;
      miss_is_store = h_store;
      miss_addr     = h_addr;
      miss_wdata    = h_wdata;
    end
    for (int i = 0; i < rsp_delay; i++) begin
      chk("wait_fill", fill_valid, 0);
      chk("wait_ready", miss_ready, 0);
      chk("wait_busy", busy, 1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("wait_ready", miss_ready, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    @(posedge clk);
    n++;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    chk("fill_valid", fill_valid, 1);
    chk("fill_index", 32'(fill_index), (addr / 4) % 16384);
    chk("fill_tag", 32'(fill_tag), addr / 65536);
    chk("fill_data", fill_data, rdata);
    // Accept cycle through fill cycle spans four cycles when nothing stalls.
    chk("fill_latency", n, 2 + stall + rsp_delay);
    chk("fill_ready", miss_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("fill_pulse_end", fill_valid, 0);
    chk("ld_busy_fall", busy, 0);
    chk("ld_ready", miss_ready, 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    miss_valid    = 1'b0;
    miss_is_store = 1'b0;
    miss_addr     = '0;
    miss_wdata    = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", miss_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk_counters("rst");

    // Load miss, memory ready, response right after the handshake.
    run_miss(0, 32'h0004_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_ld_cnt", load_miss_cnt, 1);

    // Store miss stalled three cycles on mem_req_ready.
    run_miss(1, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0, 3, 0, 0, 0, 0, 0, 0);
    chk("t2_st_cnt", store_miss_cnt, 1);

    // Second miss held during WAIT_RSP, spurious response in REQ ignored.
    run_miss(0, 32'h0000_ABC4, 32'h0, 32'h1357_9BDF, 2, 3, 1,
             1, 0, 32'h00FF_0008, 32'h0);
    run_miss(0, 32'h00FF_0008, 32'h0, 32'h2468_ACE0, 0, 1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      run_miss(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 0, 0, 0, 0);
    end
    chk_counters("random");

    // Reset while waiting for the response.
    miss_valid    = 1'b1;
    miss_is_store = 1'b0;
    miss_addr     = 32'h0ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    ld_exp = 0;
    st_exp = 0;
    chk("arst_ready", miss_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_req_valid", mem_req_valid, 0);
    chk("arst_req_we", mem_req_we, 0);
    chk("arst_req_addr", mem_req_addr, 0);
    chk("arst_req_wdata", mem_req_wdata, 0);
    chk("arst_fill_valid", fill_valid, 0);
    chk("arst_fill_index", 32'(fill_index), 0);
    chk("arst_fill_tag", 32'(fill_tag), 0);
    chk("arst_fill_data", fill_data, 0);
    chk_counters("arst");
    @(negedge clk);
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late_rsp_fill", fill_valid, 0);
    chk("late_rsp_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("late_rsp_fill2", fill_valid, 0);
    chk("late_rsp_data", fill_data, 0);
    chk_counters("post_rst");

    // Saturation of the load counter.
    force dut.u_load_cnt.count = 32'hFFFF_FFFE;
    #1 release dut.u_load_cnt.count;
    ld_exp = 32'hFFFF_FFFE;
    chk("preload", load_miss_cnt, ld_exp);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      run_miss(0, $urandom, 32'h0, $urandom, 0, $urandom_range(0, 1), 0, 0, 0, 0, 0);
      chk("sat_ld_cnt", load_miss_cnt, 32'hFFFF_FFFF);
    end
    chk("sat_st_cnt", store_miss_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_cache_miss_unit.md
Name: dm_cache_miss_unit

Overview:
- Miss-handling stage directly downstream of the direct-mapped cache lookup.
- Takes one miss at a time from the lookup stage and talks to backing memory over a valid/ready request channel plus a response channel.
- Load misses: fetches the word and returns a line fill (index, tag, data) to the cache array.
- Store misses: written through to memory with no allocate, matching the cache's no-write-allocate policy.
- Keeps saturating load-miss and store-miss counters for hit/miss statistics.

Parameters:
- ADDR_W, 32, byte address width.
- OFFSET_W, 2, word-offset bits dropped from the address.
- INDEX_W, 14, line index width (16384 lines).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W (16), tag width.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_valid  in  1  lookup stage presents a miss.
- miss_ready  out  1  unit can accept a miss.
- miss_is_store  in  1  1 = store miss, 0 = load miss.
- miss_addr  in  ADDR_W  byte address of the miss.
- miss_wdata  in  32  store data; ignored for loads.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  word-aligned request address (low OFFSET_W bits forced to 0).
- mem_req_wdata  out  32  write data.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  32  read data.
- fill_valid  out  1  one-cycle fill pulse to the cache array.
- fill_index  out  INDEX_W  miss_addr[OFFSET_W+INDEX_W-1:OFFSET_W].
- fill_tag  out  TAG_W  miss_addr[ADDR_W-1:OFFSET_W+INDEX_W].
- fill_data  out  32  data returned by memory.
- busy  out  1  state != IDLE.
- load_miss_cnt  out  CNT_W  accepted load misses.
- store_miss_cnt  out  CNT_W  accepted store misses.

Behaviour:
- Reset (async assert, sync-released logic):
  - state = IDLE; miss_ready = 1.
  - mem_req_valid, mem_req_we, fill_valid, busy = 0.
  - mem_req_addr, mem_req_wdata, fill_index, fill_tag, fill_data = 0.
  - Both counters = 0.
  - Reset mid-transaction drops the transaction silently. No fill is issued and no request is held.
- FSM states: IDLE, REQ, WAIT_RSP, FILL.
- IDLE:
  - miss_ready = 1.
  - On miss_valid && miss_ready: latch addr, wdata, is_store, index and tag; increment the matching counter; go to REQ.
  - Counters saturate at all-ones and do not wrap.
- REQ:
  - mem_req_valid = 1 from the cycle after acceptance (registered, 1-cycle latency).
  - mem_req_we = is_store.
  - Request fields stay stable until mem_req_ready is sampled high.
  - On handshake: store -> IDLE; load -> WAIT_RSP.
  - mem_req_valid never drops without a handshake.
- WAIT_RSP:
  - On mem_rsp_valid: latch mem_rsp_data into fill_data; go to FILL.
  - Responses are sampled only in WAIT_RSP. mem_rsp_valid in any other state is ignored.
  - Memory must not respond in the same cycle as the request handshake.
- FILL:
  - fill_valid = 1 for exactly one cycle with fill_index, fill_tag and fill_data; then IDLE.
  - The cache always accepts a fill (no backpressure).
- miss_ready = 0 in every state except IDLE. A miss presented while busy waits; the upstream keeps miss_valid and its fields stable.
- Minimum load latency, accept to fill_valid: 4 cycles, with mem_req_ready already high and the response one cycle after the request handshake.
- Minimum store occupancy: 2 cycles.
- Back-to-back: a new miss is accepted the cycle after return to IDLE. There is no accept in the same cycle as a FILL or store completion.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, OFFSET_W, INDEX_W, TAG_W.
  - State enum for miss-unit state.
  - Functions addr_index() and addr_tag(). The lookup stage uses the same slicing functions.
- One sub-module: sat_counter (CNT_W-wide, enable, saturate at all-ones), instantiated twice.

Test Plan:
1. Reset, then load miss at 0x0004_0010 with mem_req_ready=1 and response 0xDEADBEEF one cycle after the request handshake:
   - mem_req_addr = 0x0004_0010, we=0.
   - fill_valid pulses once with index=0x0004, tag=0x0004, data=0xDEADBEEF, 4 cycles after accept.
   - load_miss_cnt = 1.
2. Store miss at 0x1234_5678 with data 0xA5A5A5A5, mem_req_ready held low for 3 cycles:
   - Request fields stay stable and mem_req_valid stays high for all 3 stall cycles.
   - we=1, addr=0x1234_5678; no fill_valid.
   - store_miss_cnt = 1; busy falls the cycle after the handshake.
3. miss_valid held during WAIT_RSP:
   - miss_ready = 0 throughout.
   - Second miss accepted the cycle after FILL.
   - Spurious mem_rsp_valid pulsed in REQ is ignored, and fill_data equals the later WAIT_RSP response.
4. Assert rst_n=0 in WAIT_RSP:
   - All outputs return to reset values immediately (asynchronous).
   - A response arriving after reset release produces no fill.
   - Counters read 0.
5. Preload load_miss_cnt to 0xFFFF_FFFE via force, then issue 3 load misses:
   - Counter reads 0xFFFF_FFFF and stays there.
   - store_miss_cnt is unchanged.
